// File: rtl/trigger_coincidence_scheduler.sv
// trigger_coincidence_scheduler
// Gathers per-board threshold decisions over a fixed coincidence window.
// When at least MIN_HITS distinct boards fire inside the window, it issues one
// trigger request carrying the earliest time stamp and the hit mask. The
// request goes to the DRAM controller over a valid/ready handshake. Each
// accepted trigger is followed by a holdoff dead time.
module trigger_coincidence_scheduler #(
    parameter int NUM_CH   = 8,
    parameter int TS_WIDTH = 16,
    parameter int WINDOW   = 8,
    parameter int MIN_HITS = 2,
    parameter int HOLDOFF  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trig_enable,
    input  logic [NUM_CH-1:0]          decision,
    input  logic [NUM_CH*TS_WIDTH-1:0] time_stamp,
    output logic                       trigger_valid,
    input  logic                       trigger_ready,
    output logic [TS_WIDTH-1:0]        trigger_time_stamp,
    output logic [NUM_CH-1:0]          trigger_hit_mask,
    output logic                       busy,
    output logic [15:0]                reject_count,
    output logic [15:0]                drop_count
);

    // One down-counter serves both the window and the holdoff, so it is
    // sized for the larger of the two reload values.
    localparam int CNT_MAX = ((HOLDOFF - 1) > (WINDOW - 2)) ? (HOLDOFF - 1) : (WINDOW - 2);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int POP_W   = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t                 state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [NUM_CH-1:0]      mask_r, mask_next_s;
    logic [TS_WIDTH-1:0]    earliest_r, earliest_next_s;

    logic                   new_any_s;
    logic [TS_WIDTH-1:0]    new_min_s;
    logic [NUM_CH-1:0]      merged_mask_s;
    logic [TS_WIDTH-1:0]    merged_min_s;
    logic                   inc_reject_s;
    logic                   inc_drop_s;
    logic                   load_out_s;

    // Wrap-aware ordering: a is earlier than b when (a - b) mod 2^W is negative.
    function automatic logic is_earlier(input logic [TS_WIDTH-1:0] a,
                                        input logic [TS_WIDTH-1:0] b);
        logic [TS_WIDTH-1:0] diff;
        diff = a - b;
        return diff[TS_WIDTH-1];
    endfunction

    // Earliest stamp among this cycle's asserted channels. Only a strictly
    // earlier stamp replaces the current best, so the lower index wins ties.
    function automatic logic [TS_WIDTH-1:0] scan_min(input logic [NUM_CH-1:0]          dec,
                                                     input logic [NUM_CH*TS_WIDTH-1:0] ts);
        logic [TS_WIDTH-1:0] best;
        logic [TS_WIDTH-1:0] cand;
        logic                found;
        best  = '0;
        found = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            cand = ts[n*TS_WIDTH +: TS_WIDTH];
            if (dec[n] && (!found || is_earlier(cand, best))) begin
                best  = cand;
                found = 1'b1;
            end
        end
        return best;
    endfunction

    // Number of distinct channels set in a hit mask.
    function automatic logic [POP_W-1:0] popcount(input logic [NUM_CH-1:0] m);
        logic [POP_W-1:0] total;
        total = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            total = total + POP_W'(m[n]);
        end
        return total;
    endfunction

    // Saturating increment for the 16-bit event counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Next-state, counter, accumulation and event-flag logic.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        mask_next_s     = mask_r;
        earliest_next_s = earliest_r;
        inc_reject_s    = 1'b0;
        inc_drop_s      = 1'b0;
        load_out_s      = 1'b0;

        new_any_s     = |decision;
        new_min_s     = scan_min(decision, time_stamp);
        merged_mask_s = mask_r | decision;
        merged_min_s  = (new_any_s && is_earlier(new_min_s, earliest_r)) ? new_min_s : earliest_r;

        case (state_r)
            ST_IDLE: begin
                if (trig_enable && new_any_s) begin
                    state_next_s    = ST_COLLECT;
                    mask_next_s     = decision;
                    earliest_next_s = new_min_s;
                    cnt_next_s      = CNT_W'(WINDOW - 2);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                mask_next_s     = merged_mask_s;
                earliest_next_s = merged_min_s;
                if (cnt_r == '0) begin
                    if (popcount(merged_mask_s) >= POP_W'(MIN_HITS)) begin
                        state_next_s = ST_ISSUE;
                        load_out_s   = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                        inc_reject_s = 1'b1;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                inc_drop_s = new_any_s;
                if (trigger_valid && trigger_ready) begin
                    state_next_s = ST_HOLDOFF;
                    cnt_next_s   = CNT_W'(HOLDOFF - 1);
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_HOLDOFF: begin
                inc_drop_s = new_any_s;
                if (cnt_r == '0) begin
                    state_next_s = ST_IDLE;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, accumulators and all outputs are registered; outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            cnt_r              <= '0;
            mask_r             <= '0;
            earliest_r         <= '0;
            trigger_valid      <= 1'b0;
            trigger_time_stamp <= '0;
            trigger_hit_mask   <= '0;
            busy               <= 1'b0;
            reject_count       <= 16'h0000;
            drop_count         <= 16'h0000;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            mask_r        <= mask_next_s;
            earliest_r    <= earliest_next_s;
            trigger_valid <= (state_next_s == ST_ISSUE);
            busy          <= (state_next_s != ST_IDLE);
            if (load_out_s) begin
                trigger_time_stamp <= merged_min_s;
                trigger_hit_mask   <= merged_mask_s;
            end else begin
                trigger_time_stamp <= trigger_time_stamp;
                trigger_hit_mask   <= trigger_hit_mask;
            end
            if (inc_reject_s) begin
                reject_count <= sat_inc(reject_count);
            end else begin
                reject_count <= reject_count;
            end
            if (inc_drop_s) begin
                drop_count <= sat_inc(drop_count);
            end else begin
                drop_count <= drop_count;
            end
        end
    end

endmodule

// File: doc/trigger_coincidence_scheduler.md
# trigger_coincidence_scheduler

Sequences the per-board thresholder decisions into trigger requests for the DRAM capture controller. It collects the eight `Bn_decision` / `Bn_time_stamp` pairs over a programmable coincidence window and issues a trigger only when enough boards fire. Each trigger carries the earliest time stamp and the hit mask, is delivered to the DRAM controller through a valid/ready handshake, and is followed by a holdoff period. The block sits between the eight `Thresholder_integral` instances and the DRAM controller, replacing the bare global-coordinator decision path.

## Interface
- `NUM_CH`, 8: number of board channels (1..8)
- `TS_WIDTH`, 16: time-stamp width
- `WINDOW`, 8: coincidence window length in clk cycles (>= 2)
- `MIN_HITS`, 2: distinct channels required to trigger (1..NUM_CH)
- `HOLDOFF`, 64: dead time in cycles after an accepted trigger (>= 1)

- `clk`  in  1: single clock; all inputs are synchronous to it
- `rst`  in  1: synchronous reset, active-high
- `trig_enable`  in  1: when low, no new window opens; a window already in flight completes normally
- `decision`  in  NUM_CH: per-channel threshold pulse; bit n is board n
- `time_stamp`  in  NUM_CH*TS_WIDTH: channel n's stamp in bits [n*TS_WIDTH +: TS_WIDTH], valid when its decision bit is high
- `trigger_valid`  out  1: trigger request to the DRAM controller
- `trigger_ready`  in  1: DRAM controller accepts the request
- `trigger_time_stamp`  out  TS_WIDTH: earliest stamp among hit channels
- `trigger_hit_mask`  out  NUM_CH: channels that fired inside the window
- `busy`  out  1: high in any state other than IDLE
- `reject_count`  out  16: windows closed below MIN_HITS; saturating
- `drop_count`  out  16: decision cycles ignored in ISSUE/HOLDOFF; saturating

## Operation
- **States:** IDLE, COLLECT, ISSUE, HOLDOFF.
- **Counting hits:** a channel counts at most once per window. The mask is OR-accumulated, so repeated or level-high decisions do not add hits.
- **IDLE:**
  - If `trig_enable` and `|decision`: set mask = `decision`, set earliest = min of the asserted stamps, load `cnt` = WINDOW-2, go to COLLECT.
  - If `trig_enable` is low: decisions are ignored and not counted.
- **COLLECT:** on every edge, mask |= `decision` and earliest = min(earliest, new stamps).
  - If `cnt` == 0, evaluate popcount(mask including this cycle's decisions):
    - \>= MIN_HITS: go to ISSUE.
    - Otherwise: increment `reject_count` and go to IDLE.
  - If `cnt` != 0: decrement `cnt`.
- **ISSUE:** `trigger_valid` = 1. `trigger_time_stamp` and `trigger_hit_mask` are held stable until the handshake.
  - On `trigger_valid` & `trigger_ready`: load `cnt` = HOLDOFF-1 and go to HOLDOFF.
- **HOLDOFF:** when `cnt` == 0, go to IDLE; otherwise decrement `cnt`.
- **Dropped decisions:** in ISSUE or HOLDOFF, any cycle with `|decision` increments `drop_count` by 1 per cycle, not per channel.
- **Min rule (wrap-around aware):** stamp a is earlier than b if bit TS_WIDTH-1 of (a - b) mod 2^TS_WIDTH is 1.
  - Equal stamps or simultaneous asserting channels: the lowest channel index wins ties.
  - The result is valid for stamps within 2^(TS_WIDTH-1) of each other.
- **Counters:** both saturate at 0xFFFF and never wrap.
- **Reset** in any state, including mid-handshake, returns the block to IDLE on that edge:
  - `trigger_valid` = 0, `trigger_time_stamp` = 0, `trigger_hit_mask` = 0
  - `busy` = 0, `reject_count` = 0, `drop_count` = 0
  - internal mask, earliest and `cnt` cleared

## Timing
- **Window:** exactly WINDOW sampled cycles, running from the first-hit edge E0 through edge E0+WINDOW-1 inclusive.
- **Latency:** `trigger_valid` is first high in the cycle after edge E0+WINDOW-1, i.e. WINDOW cycles after E0.
- **Handshake:**
  - Transfer occurs on the edge where `trigger_valid` & `trigger_ready`.
  - `trigger_valid` drops on that same edge.
  - `trigger_ready` may be held high permanently; the minimum ISSUE duration is 1 cycle.
- **Dead time:** HOLDOFF cycles after the transfer edge. Earliest re-arm is IDLE sampling a decision HOLDOFF+1 edges after the transfer.
- **Outputs:** all registered; no combinational input-to-output path.
- **Throughput:** at most one trigger per WINDOW+HOLDOFF+1 cycles.

## Test plan
- **Basic coincidence** (defaults, `trigger_ready`=1):
  - Stimulus: ch2 pulses at E0 with stamp 0x0105; ch5 pulses at E0+3 with stamp 0x0100.
  - Response: `trigger_valid` for one cycle at E0+8; stamp 0x0100; mask 0x24; then `busy` high for 64 more cycles.
- **Sub-threshold window:**
  - Stimulus: ch0 pulses alone; later ch1 pulses at E0+8.
  - Response: no trigger; `reject_count` = 1; ch1 opens a new window at E0+8.
- **Wrap-around and tie:**
  - Stimulus: ch3 = 0xFFFE and ch6 = 0x0002, simultaneously.
  - Response: stamp 0xFFFE. With ch1 = ch4 = 0x0010, stamp 0x0010 and mask 0x12.
- **Back-pressure:**
  - Stimulus: `trigger_ready` = 0 for 20 cycles; ch7 pulses during ISSUE.
  - Response: `trigger_valid`, stamp and mask stable for all 20 cycles; `drop_count` = 1; transfer on the first ready edge.
- **Reset mid-ISSUE:**
  - Stimulus: assert `rst` while `trigger_valid` = 1.
  - Response: next cycle all outputs 0 and `busy` = 0; a fresh coincidence afterwards triggers normally.
- **Saturation / enable:**
  - Stimulus: force 70000 dropped decision cycles.
  - Response: `drop_count` holds 0xFFFF.
  - Stimulus: `trig_enable` = 0 with decisions present.
  - Response: no window opens; counters unchanged.
